tipi_ti_bus_regs: RTL and testbench
===================================

Name: tipi_ti_bus_regs

Overview:
- TI-99/4A expansion-bus side of the TIPI register file; sits directly upstream of the 4-bit Pi bus block.
- Decodes TI memory cycles in the DSR window and latches TI writes into TD/TC, which the Pi bus block exposes to the MCU.
- Drives RD/RC, which the MCU writes through the Pi bus block, onto the TI data bus during TI reads.
- Synchronises the asynchronous TI strobes into clk and emits one-cycle event pulses for the MCU-side logic.

Parameters:
- ADDR_RC, 16'h5FF9, TI byte address of RC (read-only from TI)
- ADDR_RD, 16'h5FFB, TI byte address of RD (read-only from TI)
- ADDR_TC, 16'h5FFD, TI byte address of TC (write-only from TI)
- ADDR_TD, 16'h5FFF, TI byte address of TD (write-only from TI)
- MIN_LOW, 2, synchronised cycles ti_we_n must stay low before data capture (glitch filter/settle)

Ports:
- clk  input  1  system clock, same clock as the Pi bus block
- reset  input  1  asynchronous, active-low reset
- cru_en  input  1  DSR enable (TIPI CRU bit); no decode when 0
- ti_a  input  16  TI address bus, bit 0 = LSB, asynchronous
- ti_memen_n  input  1  TI memory enable, active low, asynchronous
- ti_we_n  input  1  TI write strobe, active low, asynchronous
- ti_dbin  input  1  TI read strobe, active high, asynchronous
- ti_d_in  input  8  TI data bus (write data), asynchronous
- ti_d_out  output  8  read data toward TI data bus
- ti_d_oe  output  1  TI data bus driver enable
- RD  input  8  RD register from the Pi bus block
- RC  input  8  RC register from the Pi bus block
- TD  output  8  TD register, feeds the Pi bus block
- TC  output  8  TC register, feeds the Pi bus block
- td_wr_stb  output  1  one-cycle pulse when TD is updated
- tc_wr_stb  output  1  one-cycle pulse when TC is updated
- rd_rd_stb  output  1  one-cycle pulse at the end of a TI read of RD
- rc_rd_stb  output  1  one-cycle pulse at the end of a TI read of RC

Behaviour:
- Reset (reset=0, asynchronous): TD=0, TC=0, all strobes=0, ti_d_out=0, hold register=0, FSM=IDLE, synchroniser flops set to the inactive level (we_n=1, memen_n=1, dbin=0).
- Synchronisers: two-flop synchronisers on ti_memen_n, ti_we_n and ti_dbin. ti_a and ti_d_in are not synchronised; they are stable while their strobe is active and are sampled only at the CAPTURE point.
- Write FSM states: IDLE, WLOW, CAPTURE, WAIT_HI.
  - IDLE -> WLOW when the synced we_n is 0 and the synced memen_n is 0. The low-cycle counter loads 1.
  - WLOW: the counter increments each cycle while the synced we_n is 0. When the counter reaches MIN_LOW, go to CAPTURE. If the synced we_n returns to 1 first, return to IDLE with no capture.
  - CAPTURE (one cycle): if cru_en=1 and ti_a==ADDR_TD, latch TD<=ti_d_in and pulse td_wr_stb the next cycle. If cru_en=1 and ti_a==ADDR_TC, latch TC<=ti_d_in and pulse tc_wr_stb. Any other address, including ADDR_RD and ADDR_RC, is ignored. Then go to WAIT_HI.
  - WAIT_HI: stay until the synced we_n is 1, then go to IDLE. Exactly one capture per TI write cycle.
- Write latency: TD/TC update 2 (sync) + MIN_LOW + 1 clk after ti_we_n falls. The strobe asserts on the same edge that TD/TC updates.
- Read path:
  - ti_d_oe is combinational from the raw inputs: ti_memen_n==0 AND ti_dbin==1 AND cru_en==1 AND ti_a in {ADDR_RD, ADDR_RC}. TD and TC are never driven back.
  - ti_d_out is selected from a hold register by ti_a: ADDR_RD selects the RD copy, otherwise the RC copy.
  - The hold register copies RD and RC every clk while the synced read (memen_n=0 and dbin=1) is inactive. It freezes while the synced read is active, so an MCU update mid-read cannot tear the byte.
  - On the synced read's deassertion, if the decoded address was ADDR_RD (or ADDR_RC), pulse rd_rd_stb (or rc_rd_stb) for one cycle. The address is latched when the synced read asserts.
- cru_en=0: no capture, no ti_d_oe, no read strobes. TD and TC keep their values.
- Simultaneous: a write in progress while a read is detected is not possible on the TI bus. If it occurs, the write FSM proceeds independently and the read path still obeys its own rules.
- Reset mid-write: aborts; no capture, no strobe after release.
- Back-to-back writes: the second write is accepted only after WAIT_HI sees we_n high. Each write produces its own strobe.

Test Plan:
- Reset → TD=0, TC=0, all strobes 0, ti_d_oe=0; release reset with buses idle → outputs unchanged.
- cru_en=1, write 8'hA5 to 16'h5FFF with we_n low 6 clk → TD=8'hA5 at edge 2+MIN_LOW+1 after the we_n fall, td_wr_stb high exactly 1 cycle, TC unchanged.
- cru_en=1, we_n low only 1 clk at 16'h5FFD with data 8'h3C → TC stays 0, no tc_wr_stb. Repeat with we_n low 6 clk → TC=8'h3C.
- RD=8'h81, read 16'h5FFB with memen_n=0, dbin=1 for 8 clk; change RD to 8'h7E at clk 4 → ti_d_oe=1 throughout, ti_d_out=8'h81 stable, rd_rd_stb one pulse after dbin falls.
- cru_en=0, write 8'hFF to 16'h5FFF and read 16'h5FF9 → TD unchanged, ti_d_oe=0, no strobes.
- Write 8'h11 to 16'h5FFF, assert reset at the WLOW state → TD=0, no td_wr_stb. A following full write of 8'h22 → TD=8'h22.

Source files
------------

// File: rtl/tipi_ti_bus_regs.sv
// TI-99/4A expansion-bus side of the TIPI register file.
// Synchronises the TI strobes, captures TI writes into TD/TC through a write FSM,
// and presents a tear-free copy of RD/RC to the TI during reads.
module tipi_ti_bus_regs #(
   parameter logic [15:0] ADDR_RC = 16'h5FF9,
   parameter logic [15:0] ADDR_RD = 16'h5FFB,
   parameter logic [15:0] ADDR_TC = 16'h5FFD,
   parameter logic [15:0] ADDR_TD = 16'h5FFF,
   parameter int unsigned MIN_LOW = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cru_en,
   input  logic [15:0] ti_a,
   input  logic        ti_memen_n,
   input  logic        ti_we_n,
   input  logic        ti_dbin,
   input  logic [7:0]  ti_d_in,
   output logic [7:0]  ti_d_out,
   output logic        ti_d_oe,
   input  logic [7:0]  RD,
   input  logic [7:0]  RC,
   output logic [7:0]  TD,
   output logic [7:0]  TC,
   output logic        td_wr_stb,
   output logic        tc_wr_stb,
   output logic        rd_rd_stb,
   output logic        rc_rd_stb
);

   localparam int unsigned CNT_W = $clog2(MIN_LOW + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WLOW    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_WAIT_HI = 2'd3
   } state_t;

   logic             r_memen_s1, r_memen_s2;
   logic             r_we_s1, r_we_s2;
   logic             r_dbin_s1, r_dbin_s2;
   logic             w_we_n, w_memen_n, w_rd_act;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [7:0]       r_td, r_tc, w_td_nxt, w_tc_nxt;
   logic             r_td_stb, r_tc_stb, w_td_stb_nxt, w_tc_stb_nxt;

   logic [7:0]       r_rd_hold, r_rc_hold;
   logic             r_rd_act_q, r_sel_rd, r_sel_rc;
   logic             r_rd_rd_stb, r_rc_rd_stb;

   // Two-flop synchronisers, reset to the inactive bus levels
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_memen_s1 <= 1'b1;
         r_memen_s2 <= 1'b1;
         r_we_s1    <= 1'b1;
         r_we_s2    <= 1'b1;
         r_dbin_s1  <= 1'b0;
         r_dbin_s2  <= 1'b0;
      end else begin
         r_memen_s1 <= ti_memen_n;
         r_memen_s2 <= r_memen_s1;
         r_we_s1    <= ti_we_n;
         r_we_s2    <= r_we_s1;
         r_dbin_s1  <= ti_dbin;
         r_dbin_s2  <= r_dbin_s1;
      end
   end

   assign w_we_n    = r_we_s2;
   assign w_memen_n = r_memen_s2;
   assign w_rd_act  = ~r_memen_s2 & r_dbin_s2;
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // Write FSM state, counter and TD/TC registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_td     <= '0;
         r_tc     <= '0;
         r_td_stb <= 1'b0;
         r_tc_stb <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_td     <= w_td_nxt;
         r_tc     <= w_tc_nxt;
         r_td_stb <= w_td_stb_nxt;
         r_tc_stb <= w_tc_stb_nxt;
      end
   end

   // Write FSM next state: filter the low strobe, capture once, wait for release
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_td_nxt     = r_td;
      w_tc_nxt     = r_tc;
      w_td_stb_nxt = 1'b0;
      w_tc_stb_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_we_n && !w_memen_n) begin
               w_state_nxt = ST_WLOW;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         ST_WLOW: begin
            if (w_we_n) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc >= CNT_W'(MIN_LOW)) begin
                  w_state_nxt = ST_CAPTURE;
               end
            end
         end
         ST_CAPTURE: begin
            w_state_nxt = ST_WAIT_HI;
            if (cru_en) begin
               if (ti_a == ADDR_TD) begin
                  w_td_nxt     = ti_d_in;
                  w_td_stb_nxt = 1'b1;
               end else if (ti_a == ADDR_TC) begin
                  w_tc_nxt     = ti_d_in;
                  w_tc_stb_nxt = 1'b1;
               end
            end
         end
         ST_WAIT_HI: begin
            if (w_we_n) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Hold copy of RD/RC, frozen while a synchronised read is active
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_hold <= '0;
         r_rc_hold <= '0;
      end else if (!w_rd_act) begin
         r_rd_hold <= RD;
         r_rc_hold <= RC;
      end
   end

   // Latch read address on read start, pulse the matching strobe on read end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_act_q  <= 1'b0;
         r_sel_rd    <= 1'b0;
         r_sel_rc    <= 1'b0;
         r_rd_rd_stb <= 1'b0;
         r_rc_rd_stb <= 1'b0;
      end else begin
         r_rd_act_q <= w_rd_act;
         if (w_rd_act && !r_rd_act_q) begin
            r_sel_rd <= cru_en && (ti_a == ADDR_RD);
            r_sel_rc <= cru_en && (ti_a == ADDR_RC);
         end
         r_rd_rd_stb <= r_rd_act_q && !w_rd_act && r_sel_rd;
         r_rc_rd_stb <= r_rd_act_q && !w_rd_act && r_sel_rc;
      end
   end

   assign ti_d_oe   = ~ti_memen_n & ti_dbin & cru_en & ((ti_a == ADDR_RD) | (ti_a == ADDR_RC));
   assign ti_d_out  = (ti_a == ADDR_RD) ? r_rd_hold : r_rc_hold;
   assign TD        = r_td;
   assign TC        = r_tc;
   assign td_wr_stb = r_td_stb;
   assign tc_wr_stb = r_tc_stb;
   assign rd_rd_stb = r_rd_rd_stb;
   assign rc_rd_stb = r_rc_rd_stb;

endmodule

// File: tb/tb_tipi_ti_bus_regs.sv
// Bench for tipi_ti_bus_regs: directed TI bus cycles, a per-cycle behavioural
// model compared every clock, and literal expectations for the key scenarios.
module tb_tipi_ti_bus_regs;

   localparam logic [15:0] A_RC = 16'h5FF9;
   localparam logic [15:0] A_RD = 16'h5FFB;
   localparam logic [15:0] A_TC = 16'h5FFD;
   localparam logic [15:0] A_TD = 16'h5FFF;
   localparam int          MINL = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        cru_en;
   logic [15:0] ti_a;
   logic        ti_memen_n, ti_we_n, ti_dbin;
   logic [7:0]  ti_d_in, tb_rd, tb_rc;
   logic [7:0]  ti_d_out, TD, TC;
   logic        ti_d_oe, td_wr_stb, tc_wr_stb, rd_rd_stb, rc_rd_stb;

   int vectors = 0;
   int miscompares = 0;
   int n_td = 0, n_tc = 0, n_rd = 0, n_rc = 0;

   tipi_ti_bus_regs dut (
      .clk(clk), .reset(reset), .cru_en(cru_en), .ti_a(ti_a),
      .ti_memen_n(ti_memen_n), .ti_we_n(ti_we_n), .ti_dbin(ti_dbin),
      .ti_d_in(ti_d_in), .ti_d_out(ti_d_out), .ti_d_oe(ti_d_oe),
      .RD(tb_rd), .RC(tb_rc), .TD(TD), .TC(TC),
      .td_wr_stb(td_wr_stb), .tc_wr_stb(tc_wr_stb),
      .rd_rd_stb(rd_rd_stb), .rc_rd_stb(rc_rd_stb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Synced strobe = raw level two edges ago. A write is captured once per
   // synced-low run of we_n (started with memen low), on the edge after the run
   // has lasted MINL cycles. Reads freeze the RD/RC copy and strobe on release.
   logic       m_we1, m_we2, m_me1, m_me2, m_db1, m_db2;
   int         m_run;
   bit         m_done, m_cap, m_act_prev, m_sel_rd, m_sel_rc;
   logic [7:0] m_td, m_tc, m_hrd, m_hrc;
   logic       m_td_stb, m_tc_stb, m_rd_stb, m_rc_stb;

   always @(posedge clk or negedge reset) begin
      logic we_s, me_s, db_s;
      bit   act;
      if (!reset) begin
         m_we1 = 1; m_we2 = 1; m_me1 = 1; m_me2 = 1; m_db1 = 0; m_db2 = 0;
         m_run = 0; m_done = 0; m_cap = 0; m_act_prev = 0; m_sel_rd = 0; m_sel_rc = 0;
         m_td = 0; m_tc = 0; m_hrd = 0; m_hrc = 0;
         m_td_stb = 0; m_tc_stb = 0; m_rd_stb = 0; m_rc_stb = 0;
      end else begin
         we_s = m_we2; me_s = m_me2; db_s = m_db2;
         m_we2 = m_we1; m_we1 = ti_we_n;
         m_me2 = m_me1; m_me1 = ti_memen_n;
         m_db2 = m_db1; m_db1 = ti_dbin;
         m_td_stb = 0; m_tc_stb = 0;
         if (m_cap) begin
            m_cap = 0;
            if (cru_en && ti_a == A_TD) begin m_td = ti_d_in; m_td_stb = 1; end
            else if (cru_en && ti_a == A_TC) begin m_tc = ti_d_in; m_tc_stb = 1; end
         end
         if (!we_s) begin
            if (m_run > 0 || !me_s) m_run++;
         end else begin
            m_run = 0; m_done = 0;
         end
         if (m_run == MINL && !m_done) begin m_cap = 1; m_done = 1; end
         act = !me_s && db_s;
         if (!act) begin m_hrd = tb_rd; m_hrc = tb_rc; end
         m_rd_stb = m_act_prev && !act && m_sel_rd;
         m_rc_stb = m_act_prev && !act && m_sel_rc;
         if (act && !m_act_prev) begin
            m_sel_rd = cru_en && ti_a == A_RD;
            m_sel_rc = cru_en && ti_a == A_RC;
         end
         m_act_prev = act;
      end
   end

   // Per-cycle compare of every output against the model
   always @(posedge clk) begin
      logic exp_oe;
      #1;
      exp_oe = !ti_memen_n && ti_dbin && cru_en && (ti_a == A_RD || ti_a == A_RC);
      chk("model_TD", 16'(TD), 16'(m_td));
      chk("model_TC", 16'(TC), 16'(m_tc));
      chk("model_td_stb", 16'(td_wr_stb), 16'(m_td_stb));
      chk("model_tc_stb", 16'(tc_wr_stb), 16'(m_tc_stb));
      chk("model_rd_stb", 16'(rd_rd_stb), 16'(m_rd_stb));
      chk("model_rc_stb", 16'(rc_rd_stb), 16'(m_rc_stb));
      chk("model_oe", 16'(ti_d_oe), 16'(exp_oe));
      chk("model_dout", 16'(ti_d_out), 16'((ti_a == A_RD) ? m_hrd : m_hrc));
   end

   // Strobe pulse counters
   always @(posedge clk) begin
      #1;
      if (td_wr_stb) n_td++;
      if (tc_wr_stb) n_tc++;
      if (rd_rd_stb) n_rd++;
      if (rc_rd_stb) n_rc++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ti_write(input logic [15:0] a, input logic [7:0] d, input int low);
      @(negedge clk);
      ti_a = a; ti_d_in = d; ti_memen_n = 0; ti_we_n = 0;
      repeat (low) @(negedge clk);
      ti_we_n = 1; ti_memen_n = 1;
      idle(6);
   endtask

   // Read cycle; checks oe and data every cycle, optionally changes RD midway
   task automatic ti_read(input logic [15:0] a, input int len, input logic exp_oe,
                          input logic [7:0] exp_d, input bit bump);
      @(negedge clk);
      ti_a = a; ti_memen_n = 0; ti_dbin = 1;
      for (int i = 1; i <= len; i++) begin
         @(posedge clk); #2;
         chk("read_oe", 16'(ti_d_oe), 16'(exp_oe));
         if (exp_oe) chk("read_dout", 16'(ti_d_out), 16'(exp_d));
         @(negedge clk);
         if (bump && i == 4) tb_rd = 8'h7E;
      end
      ti_dbin = 0; ti_memen_n = 1;
      idle(6);
   endtask

   initial begin
      int lat, cnt0, cnt1;
      bit seen;
      reset = 0; cru_en = 1; ti_a = 16'h0000; ti_memen_n = 1; ti_we_n = 1; ti_dbin = 0;
      ti_d_in = 8'h00; tb_rd = 8'h00; tb_rc = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_TD", 16'(TD), 16'h0);
      chk("rst_TC", 16'(TC), 16'h0);
      chk("rst_oe", 16'(ti_d_oe), 16'h0);
      chk("rst_strobes", 16'({td_wr_stb, tc_wr_stb, rd_rd_stb, rc_rd_stb}), 16'h0);
      chk("rst_dout", 16'(ti_d_out), 16'h0);
      @(negedge clk); reset = 1;
      idle(4);
      chk("rel_TD", 16'(TD), 16'h0);
      chk("rel_TC", 16'(TC), 16'h0);

      // Full write of A5 to TD: latency 2 + MINL + 1 edges after we_n falls
      ti_a = A_TD; ti_d_in = 8'hA5; ti_memen_n = 0; ti_we_n = 0;
      lat = 0; seen = 0; cnt0 = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #2;
         if (!seen && TD == 8'hA5) begin seen = 1; lat = i; end
         if (td_wr_stb) cnt0++;
         @(negedge clk);
         if (i == 6) begin ti_we_n = 1; ti_memen_n = 1; end
      end
      chk("wr_latency", 16'(lat), 16'(5));
      chk("wr_td_stb_pulses", 16'(cnt0), 16'(1));
      chk("wr_TD", 16'(TD), 16'h00A5);
      chk("wr_TC_unchanged", 16'(TC), 16'h0);

      // Glitch-length write to TC is filtered, full-length write lands
      cnt1 = n_tc;
      ti_write(A_TC, 8'h3C, 1);
      chk("glitch_TC", 16'(TC), 16'h0);
      chk("glitch_tc_stb", 16'(n_tc - cnt1), 16'(0));
      ti_write(A_TC, 8'h3C, 6);
      chk("full_TC", 16'(TC), 16'h003C);
      chk("full_tc_stb", 16'(n_tc - cnt1), 16'(1));

      // Read RD with a mid-read MCU update: byte stays 81, one strobe
      tb_rd = 8'h81; tb_rc = 8'h5A;
      idle(3);
      cnt1 = n_rd;
      ti_read(A_RD, 8, 1'b1, 8'h81, 1'b1);
      chk("rd_stb_pulses", 16'(n_rd - cnt1), 16'(1));

      // Read RC
      cnt1 = n_rc;
      ti_read(A_RC, 4, 1'b1, 8'h5A, 1'b0);
      chk("rc_stb_pulses", 16'(n_rc - cnt1), 16'(1));

      // DSR disabled: no capture, no drive, no strobes
      cru_en = 0;
      cnt0 = n_td; cnt1 = n_rc;
      ti_write(A_TD, 8'hFF, 6);
      ti_read(A_RC, 4, 1'b0, 8'h00, 1'b0);
      chk("cru0_TD", 16'(TD), 16'h00A5);
      chk("cru0_td_stb", 16'(n_td - cnt0), 16'(0));
      chk("cru0_rc_stb", 16'(n_rc - cnt1), 16'(0));
      cru_en = 1;

      // Reset during WLOW aborts the write
      @(negedge clk);
      cnt0 = n_td;
      ti_a = A_TD; ti_d_in = 8'h11; ti_memen_n = 0; ti_we_n = 0;
      repeat (3) @(posedge clk);
      #3;
      reset = 0; ti_we_n = 1; ti_memen_n = 1;
      idle(2);
      reset = 1;
      idle(8);
      chk("abort_TD", 16'(TD), 16'h0);
      chk("abort_td_stb", 16'(n_td - cnt0), 16'(0));
      ti_write(A_TD, 8'h22, 6);
      chk("after_abort_TD", 16'(TD), 16'h0022);
      chk("after_abort_td_stb", 16'(n_td - cnt0), 16'(1));

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
